dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MEM stage of the pipelined MIPS core. It is the memory-side end of the datapath's memory interface: it accepts the load/store request presented by the EX/MEM register, applies a parameterised wait-state latency, and commits stores or returns load data. While an access is in progress it holds the pipeline with a stall request back to the hazard logic. It also exposes the 16-bit test observation value.

## Interface
- width, 32, data and address word width.
- DEPTH, 64, memory depth in words; power of two, at least 2.
- WAIT_CYCLES, 2, stall cycles per access; range 0–15.

- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- MemToRegM  input  1  load request.
- MemWriteM  input  1  store request; has priority if both request inputs are high.
- ALUOutM  input  width  byte address; word index = ALUOutM[log2(DEPTH)+1:2]. Bits [1:0] and upper bits are ignored, so addresses wrap modulo DEPTH words.
- WriteDataM  input  width  store data.
- ReadDataM  output  width  load data.
- MemStallM  output  1  stall request; when high, the core freezes the F, D, E and M stages.
- testVal  output  16  continuous view of mem[0][15:0].

## Operation
- **Request:** req = MemToRegM | MemWriteM. Inputs are sampled only in IDLE. The core holds them stable while MemStallM is high.
- **FSM states:** IDLE, WAIT, RESP. A 4-bit counter cnt tracks wait cycles.
- **IDLE:**
  - no req: stay in IDLE, MemStallM = 0.
  - req and WAIT_CYCLES = 0: zero-latency path, described below; stay in IDLE.
  - req and WAIT_CYCLES ≥ 1: latch address, data and type; cnt ← 1; MemStallM = 1 combinationally in this same cycle. Go to RESP if WAIT_CYCLES = 1, otherwise go to WAIT.
- **WAIT:** MemStallM = 1; cnt ← cnt+1. When cnt = WAIT_CYCLES−1, go to RESP. At that same edge, the store is written to the array, or ReadDataM ← mem[index].
- **RESP:** MemStallM = 0; ReadDataM is valid. The pipeline advances at the end of this cycle. Request inputs are ignored here, because they still belong to the completed access. Next state is IDLE.
- **Zero-latency path (WAIT_CYCLES = 0):**
  - ReadDataM = mem[index], combinational.
  - Store written at the next rising edge.
  - MemStallM is constantly 0.
- **ReadDataM hold:** when WAIT_CYCLES ≥ 1, ReadDataM keeps its last registered value outside RESP.
- **Store then load, same word:** the load returns the new data, because the store is committed before the load is sampled.
- **Reset (async, any state):**
  - Outputs: FSM → IDLE, cnt = 0, MemStallM = 0, ReadDataM = 0.
  - Array cleared to 0, so testVal = 0.
  - An uncommitted store in progress is discarded.

## Timing
- **Access length:** with WAIT_CYCLES = N ≥ 1, an access spans N+1 cycles in MEM: N stalled cycles then one RESP cycle.
- **Commit point:** store commit and load data capture happen at the edge that enters RESP.
- **Back-to-back accesses:** the next instruction's request is seen in the IDLE cycle right after RESP. There is no dead cycle beyond RESP.
- **No request:** MEM stage costs 0 extra cycles.
- **testVal:** follows a store to word 0 from the cycle after the commit edge.

## Configuration
- **DMEM_POSTED_WRITE_EN defined:**
  - Stores never stall. In IDLE, a store writes the array at the next edge; MemStallM = 0 and the FSM stays in IDLE.
  - Loads still follow the wait-state sequence.
- **DMEM_POSTED_WRITE_EN undefined:** stores and loads both take the full N+1-cycle sequence above.

## Test plan
- **Reset defaults:** RST pulse mid-WAIT of a store (N=2) → MemStallM = 0 and ReadDataM = 0 immediately; a subsequent load of that address returns 0.
- **Store/load timing:** N=2, store 0xDEADBEEF at 0x10, then load 0x10 → MemStallM high for 2 cycles for each access; the load's RESP shows ReadDataM = 0xDEADBEEF.
- **Zero latency:** N=0, store 0x1234 at 0x0 then load 0x0 in the next cycle → no stall, ReadDataM = 0x00001234, testVal = 0x1234.
- **Address wrap:** DEPTH=64, store 0xA5A5A5A5 at 0x100 → load at 0x0 returns 0xA5A5A5A5.
- **Back-to-back:** N=3, load 0x4 immediately followed by load 0x8 → stall pattern 1,1,1,0,1,1,1,0; each RESP returns the correct word.
- **Posted writes:** with DMEM_POSTED_WRITE_EN and N=2, store 0x55 at 0x20 → no stall cycle; a following load of 0x20 stalls 2 cycles and returns 0x00000055.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory. With WAIT_CYCLES=N, each access takes N stalled cycles plus one RESP cycle; with N=0 it is combinational.
// MemStallM freezes the core while an access is pending. Defining DMEM_POSTED_WRITE_EN makes stores non-stalling.
module dmem_responder #(
  parameter int width       = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemToRegM,
  input  logic             MemWriteM,
  input  logic [width-1:0] ALUOutM,
  input  logic [width-1:0] WriteDataM,
  output logic [width-1:0] ReadDataM,
  output logic             MemStallM,
  output logic [15:0]      testVal
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [width-1:0] wdat_q, wdat_d;
  logic             st_q, st_d;
  logic [width-1:0] rdat_q, rdat_d;
  logic [width-1:0] mem_q [DEPTH];

  logic [AW-1:0]    idx_in;
  logic             req;
  logic             stall;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [width-1:0] wr_dat;
  logic             unused_addr_bits;

  assign idx_in           = ALUOutM[AW+1:2];
  assign req              = MemToRegM | MemWriteM;
  assign unused_addr_bits = ^{ALUOutM[width-1:AW+2], ALUOutM[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    st_d    = st_q;
    rdat_d  = rdat_q;
    stall   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_dat  = wdat_q;
    unique case (state_q)
      S_IDLE: begin
        wr_idx = idx_in;
        wr_dat = WriteDataM;
        if (req) begin
          if (WAIT_CYCLES == 0 || (POSTED && MemWriteM)) begin
            wr_en = MemWriteM;
          end else begin
            idx_d  = idx_in;
            wdat_d = WriteDataM;
            st_d   = MemWriteM;
            cnt_d  = 4'd1;
            stall  = 1'b1;
            if (WAIT_CYCLES == 1) begin
              // Single wait state: the edge leaving IDLE is already the commit edge.
              state_d = S_RESP;
              wr_en   = MemWriteM;
              if (!MemWriteM) rdat_d = mem_q[idx_in];
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
          wr_en   = st_q;
          if (!st_q) rdat_d = mem_q[idx_q];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= '0;
      st_q    <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      st_q    <= st_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // The core may still hold a request during reset; the stall must drop at once.
  assign MemStallM = stall & ~RST;
  assign ReadDataM = (WAIT_CYCLES == 0) ? mem_q[idx_in] : rdat_q;
  assign testVal   = mem_q[0][15:0];
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four latency/depth configurations driven by a core-like stimulus schedule.
// The reference model predicts stall, ReadDataM and testVal for every cycle, and a monitor pops and compares them at negedge.
`timescale 1ns/1ps
module tb_dmem_responder;
  typedef struct packed {
    logic        stall;
    logic [31:0] rd;
    logic [15:0] tv;
  } exp_t;

  localparam int NCFG = 4;
`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int N = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 3 : 1;
    localparam int D = (g == 0) ? 64 : (g == 1) ? 16 : (g == 2) ? 64 : 8;

    logic        rst, ld, st;
    logic [31:0] addr, wdat, rdat;
    logic        stall;
    logic [15:0] tv;
    exp_t        expq[$];
    logic [31:0] ref_mem [D];
    logic [31:0] last_rd;

    dmem_responder #(.width(32), .DEPTH(D), .WAIT_CYCLES(N)) dut (
      .CLK(clk), .RST(rst), .MemToRegM(ld), .MemWriteM(st), .ALUOutM(addr),
      .WriteDataM(wdat), .ReadDataM(rdat), .MemStallM(stall), .testVal(tv)
    );

    function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 32'(D));
    endfunction

    // ReadDataM in a non-stalled request cycle: live array read for N=0, else the held load value.
    function automatic logic [31:0] idle_rd(input int w);
      return (N == 0) ? ref_mem[w] : last_rd;
    endfunction

    function automatic logic [31:0] rand_addr();
      logic [31:0] a, m;
      a = $urandom;
      m = 32'(D * 4 - 4);
      if ($urandom_range(0, 3) != 0) a = (a & ~m) | (32'($urandom_range(0, 7) % D) << 2);
      return a;
    endfunction

    task automatic push(input logic s, input logic [31:0] r);
      exp_t e;
      e.stall = s;
      e.rd    = r;
      e.tv    = ref_mem[0][15:0];
      expq.push_back(e);
    endtask

    task automatic next_cycle();
      @(posedge clk);
      #1;
    endtask

    task automatic clear_model();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      last_rd = '0;
    endtask

    task automatic op(input logic is_ld, input logic is_st, input logic [31:0] a, input logic [31:0] d);
      int w;
      w = widx(a);
      next_cycle();
      rst = 1'b0; ld = is_ld; st = is_st; addr = a; wdat = d;
      if (!(is_ld || is_st) || N == 0 || (POSTED && is_st)) begin
        push(1'b0, idle_rd(w));
        if (is_st) ref_mem[w] = d;
      end else begin
        push(1'b1, last_rd);
        for (int c = 1; c < N; c++) begin
          next_cycle();
          push(1'b1, last_rd);
        end
        if (is_st) ref_mem[w] = d;
        else last_rd = ref_mem[w];
        next_cycle();
        // Request lines during RESP still belong to the finished access and must have no effect.
        ld = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
        addr = $urandom; wdat = $urandom;
        push(1'b0, last_rd);
      end
    endtask

    task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
      int w;
      w = widx(a);
      next_cycle();
      rst = 1'b0; ld = 1'b0; st = 1'b1; addr = a; wdat = d;
      push(N != 0 && !POSTED, idle_rd(w));
      if (N == 0 || POSTED) ref_mem[w] = d;
      next_cycle();
      #2 rst = 1'b1;
      clear_model();
      push(1'b0, 32'h0);
    endtask

    initial begin : drv
      int kind;
      rst = 1'b1; ld = 1'b0; st = 1'b0; addr = '0; wdat = '0;
      clear_model();
      repeat (2) begin
        next_cycle();
        push(1'b0, 32'h0);
      end
      op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      op(1'b1, 1'b0, 32'h10, 32'h0);
      op(1'b0, 1'b1, 32'h0, 32'h00001234);
      op(1'b1, 1'b0, 32'h0, 32'h0);
      op(1'b0, 1'b1, 32'h100, 32'hA5A5A5A5);
      op(1'b1, 1'b0, 32'h0, 32'h0);
      op(1'b1, 1'b0, 32'h4, 32'h0);
      op(1'b1, 1'b0, 32'h8, 32'h0);
      op(1'b0, 1'b1, 32'h20, 32'h00000055);
      op(1'b1, 1'b0, 32'h20, 32'h0);
      op(1'b1, 1'b1, 32'h0, 32'hCAFE0F0F);
      op(1'b1, 1'b0, 32'h0, 32'h0);
      reset_mid_store(32'h10, 32'h77777777);
      op(1'b1, 1'b0, 32'h10, 32'h0);
      for (int k = 0; k < 300; k++) begin
        kind = $urandom_range(0, 4);
        op(kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 3, rand_addr(), $urandom);
      end
      next_cycle();
      ld = 1'b0; st = 1'b0;
      ndone++;
    end

    initial begin : mon
      exp_t e;
      int   cyc;
      cyc = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checks++;
          if (stall !== e.stall) begin
            errors++;
            $display("FAIL cfg%0d stall cyc%0d got %b want %b", g, cyc, stall, e.stall);
          end
          checks++;
          if (rdat !== e.rd) begin
            errors++;
            $display("FAIL cfg%0d ReadDataM cyc%0d got %h want %h", g, cyc, rdat, e.rd);
          end
          checks++;
          if (tv !== e.tv) begin
            errors++;
            $display("FAIL cfg%0d testVal cyc%0d got %h want %h", g, cyc, tv, e.tv);
          end
        end
      end
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (ndone < NCFG && t < 50000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (ndone < NCFG) begin
      errors++;
      $display("FAIL timeout drivers done %0d want %0d", ndone, NCFG);
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
